lab3_g29_p3_tdm_demux_16ch: RTL and testbench

// - Registered 1-to-16 demultiplexer; the distribution end of the 16:1 channel mux path.
// - Takes one WIDTH-bit sample per valid cycle and stores it in one of N_CH channel registers.
// - Channel choice: explicit select (addressed mode) or internal round-robin pointer (auto/TDM mode).
// - Marks which channels hold fresh data; pulses frame_done when an auto-mode frame completes.

---
 rtl/lab3_g29_p3_tdm_demux_16ch.sv | 78 +++++++
 tb/tb_lab3_g29_p3_tdm_demux_16ch.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/lab3_g29_p3_tdm_demux_16ch.sv
// Registered 1-to-N_CH TDM demultiplexer with addressed and round-robin modes.
// Tracks per-channel fresh flags and pulses frame_done on auto-mode wrap.
module lab3_g29_p3_tdm_demux_16ch #(
    parameter int WIDTH = 4,
    parameter int N_CH  = 16,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      din,
    input  logic                  din_valid,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  auto_mode,
    input  logic                  clear_frame,
    output logic [WIDTH*N_CH-1:0] out_bus,
    output logic [N_CH-1:0]       out_fresh,
    output logic [SEL_W-1:0]      ptr,
    output logic                  frame_done
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    logic [SEL_W-1:0] target;
    logic [N_CH-1:0]  wr_en;
    logic             auto_wr;
    logic             wrap_wr;

    always_comb begin
        target  = auto_mode ? ptr : sel;
        auto_wr = din_valid && auto_mode;
        wrap_wr = auto_wr && (ptr == LAST_CH);
        wr_en   = '0;
        if (din_valid) begin
            wr_en[target] = 1'b1;
        end
    end

    // One data register per channel; only the decoded target loads.
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        always_ff @(posedge clk) begin
            if (rst) begin
                out_bus[WIDTH*i +: WIDTH] <= '0;
            end else if (wr_en[i]) begin
                out_bus[WIDTH*i +: WIDTH] <= din;
            end
        end
    end

    // A same-cycle write survives clear_frame and keeps its own fresh bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_fresh <= '0;
        end else if (clear_frame) begin
            out_fresh <= wr_en;
        end else begin
            out_fresh <= out_fresh | wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (clear_frame) begin
            ptr <= '0;
        end else if (auto_wr) begin
            ptr <= ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap_wr;
        end
    end

endmodule

// File: tb/tb_lab3_g29_p3_tdm_demux_16ch.sv
// Directed bench for the 16-channel TDM demux.
// Table-driven vectors plus hand-written multi-cycle sequences.
module tb_lab3_g29_p3_tdm_demux_16ch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  din = '0;
    logic        din_valid = 1'b0;
    logic [3:0]  sel = '0;
    logic        auto_mode = 1'b0;
    logic        clear_frame = 1'b0;
    logic [63:0] out_bus;
    logic [15:0] out_fresh;
    logic [3:0]  ptr;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lab3_g29_p3_tdm_demux_16ch dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_valid(din_valid),
        .sel(sel),
        .auto_mode(auto_mode),
        .clear_frame(clear_frame),
        .out_bus(out_bus),
        .out_fresh(out_fresh),
        .ptr(ptr),
        .frame_done(frame_done)
    );

    typedef struct {
        logic        r;
        logic        v;
        logic        a;
        logic        c;
        logic [3:0]  s;
        logic [3:0]  d;
        int          ch;
        logic [3:0]  ech;
        logic [15:0] efr;
        logic [3:0]  eptr;
        logic        efd;
    } vec_t;

    vec_t tv[23];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic a,
                       input logic c, input logic [3:0] s,
                       input logic [3:0] d);
        @(negedge clk);
        rst = r;
        din_valid = v;
        auto_mode = a;
        clear_frame = c;
        sel = s;
        din = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] chan(input int i);
        return out_bus[4*i +: 4];
    endfunction

    initial begin
        //          r   v   a   c   sel   din   ch  ech   fresh     ptr  fd
        tv[0]  = '{1'b1,1'b0,1'b0,1'b0,4'd0, 4'h0, 0, 4'h0,16'h0000,4'd0,1'b0};
        tv[1]  = '{1'b1,1'b0,1'b0,1'b0,4'd0, 4'h0,15, 4'h0,16'h0000,4'd0,1'b0};
        tv[2]  = '{1'b0,1'b0,1'b0,1'b0,4'd3, 4'hF, 3, 4'h0,16'h0000,4'd0,1'b0};
        tv[3]  = '{1'b0,1'b0,1'b1,1'b0,4'd0, 4'hF, 0, 4'h0,16'h0000,4'd0,1'b0};
        tv[4]  = '{1'b0,1'b0,1'b0,1'b0,4'd7, 4'h1, 7, 4'h0,16'h0000,4'd0,1'b0};
        tv[5]  = '{1'b0,1'b0,1'b1,1'b0,4'd0, 4'h2, 1, 4'h0,16'h0000,4'd0,1'b0};
        tv[6]  = '{1'b0,1'b0,1'b0,1'b0,4'd0, 4'h3,15, 4'h0,16'h0000,4'd0,1'b0};
        tv[7]  = '{1'b0,1'b1,1'b0,1'b0,4'd3, 4'hA, 3, 4'hA,16'h0008,4'd0,1'b0};
        tv[8]  = '{1'b0,1'b1,1'b0,1'b0,4'd15,4'h7,15, 4'h7,16'h8008,4'd0,1'b0};
        tv[9]  = '{1'b0,1'b0,1'b0,1'b0,4'd0, 4'h0, 3, 4'hA,16'h8008,4'd0,1'b0};
        tv[10] = '{1'b0,1'b0,1'b0,1'b1,4'd0, 4'h0, 3, 4'hA,16'h0000,4'd0,1'b0};
        tv[11] = '{1'b0,1'b1,1'b1,1'b0,4'd9, 4'h5, 0, 4'h5,16'h0001,4'd1,1'b0};
        tv[12] = '{1'b0,1'b0,1'b1,1'b0,4'd0, 4'h9, 0, 4'h5,16'h0001,4'd1,1'b0};
        tv[13] = '{1'b0,1'b1,1'b1,1'b0,4'd9, 4'h5, 1, 4'h5,16'h0003,4'd2,1'b0};
        tv[14] = '{1'b0,1'b0,1'b1,1'b0,4'd0, 4'h9, 1, 4'h5,16'h0003,4'd2,1'b0};
        tv[15] = '{1'b0,1'b1,1'b1,1'b0,4'd9, 4'h5, 2, 4'h5,16'h0007,4'd3,1'b0};
        tv[16] = '{1'b0,1'b0,1'b1,1'b0,4'd0, 4'h9, 3, 4'hA,16'h0007,4'd3,1'b0};
        tv[17] = '{1'b0,1'b1,1'b0,1'b0,4'd9, 4'h2, 9, 4'h2,16'h0207,4'd3,1'b0};
        tv[18] = '{1'b0,1'b1,1'b1,1'b0,4'd9, 4'h6, 3, 4'h6,16'h020F,4'd4,1'b0};
        tv[19] = '{1'b0,1'b1,1'b1,1'b0,4'd9, 4'h1, 4, 4'h1,16'h021F,4'd5,1'b0};
        tv[20] = '{1'b0,1'b1,1'b1,1'b1,4'd9, 4'hC, 5, 4'hC,16'h0020,4'd0,1'b0};
        tv[21] = '{1'b0,1'b0,1'b0,1'b0,4'd0, 4'h0, 9, 4'h2,16'h0020,4'd0,1'b0};
        tv[22] = '{1'b0,1'b1,1'b0,1'b0,4'd5, 4'h3, 5, 4'h3,16'h0020,4'd0,1'b0};

        for (int i = 0; i < 23; i++) begin
            cyc(tv[i].r, tv[i].v, tv[i].a, tv[i].c, tv[i].s, tv[i].d);
            chk($sformatf("vec%0d ch%0d", i, tv[i].ch), 64'(chan(tv[i].ch)),
                64'(tv[i].ech));
            chk($sformatf("vec%0d fresh", i), 64'(out_fresh), 64'(tv[i].efr));
            chk($sformatf("vec%0d ptr", i), 64'(ptr), 64'(tv[i].eptr));
            chk($sformatf("vec%0d fd", i), 64'(frame_done), 64'(tv[i].efd));
        end

        // Full auto frame from a clean state.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'h0);
        chk("rst bus", out_bus, 64'h0);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'(i));
            chk($sformatf("frame fd%0d", i), 64'(frame_done),
                64'(i == 15));
            chk($sformatf("frame ptr%0d", i), 64'(ptr), 64'((i + 1) % 16));
        end
        chk("frame bus", out_bus, 64'hFEDC_BA98_7654_3210);
        chk("frame fresh", 64'(out_fresh), 64'hFFFF);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'h0);
        chk("frame fd idle", 64'(frame_done), 64'h0);
        chk("frame bus idle", out_bus, 64'hFEDC_BA98_7654_3210);

        // Clear collision at the wrap slot still pulses frame_done.
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'h0);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'h1);
        end
        chk("wrapclr ptr pre", 64'(ptr), 64'd15);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'd2, 4'hE);
        chk("wrapclr ch15", 64'(chan(15)), 64'hE);
        chk("wrapclr fresh", 64'(out_fresh), 64'h8000);
        chk("wrapclr ptr", 64'(ptr), 64'd0);
        chk("wrapclr fd", 64'(frame_done), 64'd1);
        chk("wrapclr ch2", 64'(chan(2)), 64'h1);

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'h8);
        end
        chk("mid ptr pre", 64'(ptr), 64'd8);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'h8);
        chk("mid bus", out_bus, 64'h0);
        chk("mid fresh", 64'(out_fresh), 64'h0);
        chk("mid ptr", 64'(ptr), 64'h0);
        chk("mid fd", 64'(frame_done), 64'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'h9);
        chk("post bus", out_bus, 64'h9);
        chk("post fresh", 64'(out_fresh), 64'h1);
        chk("post ptr", 64'(ptr), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
